// File: rtl/serial_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : serial_frame_receiver
//  Description : Deserialises a length-prefixed frame that follows an upstream
//                sync pulse. The frame is a length byte L, L payload bytes and
//                one checksum byte (L XOR all payload bytes). Payload bytes go
//                into a small output FIFO with a ready/valid handshake. A
//                one-cycle status pulse is raised at the end of every frame.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    FIFO_DEPTH  output byte buffer depth (power of 2, >= 2)
//  Ports
//    clk         sole clock, rising edge
//    rst         asynchronous active-high reset
//    data_in     serial bit, MSB first within each byte
//    bit_valid   data_in is sampled only when high
//    sync_found  one-cycle pulse on the last sync bit (honoured only in IDLE)
//    out_data    payload byte at the FIFO head (0x00 when empty)
//    out_valid   out_data holds a valid byte
//    out_ready   consumer accepts the head byte
//    out_last    head byte is the final payload byte of its frame
//    busy        high whenever a frame is being received
//    frame_done  one-cycle pulse at the end of a frame
//    frame_ok    checksum matched and nothing was dropped (with frame_done)
// ============================================================================
module serial_frame_receiver #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in,
    input  logic       bit_valid,
    input  logic       sync_found,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_ok
);

    localparam int ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CHECK   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_q, shift_d;       // first seven bits of the byte in flight
    logic [7:0]  len_cnt_q, len_cnt_d;
    logic [7:0]  csum_q, csum_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;

    logic [7:0]  w_byte;
    logic        w_byte_done;
    logic        w_push_req;
    logic        w_push_last;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [8:0]        mem_q [FIFO_DEPTH];   // {last, data}
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              w_pop;
    logic              w_push_ok;
    logic              w_push_drop;

    // The byte as it will look once the current bit is shifted in; only
    // meaningful on the cycle that completes it.
    assign w_byte      = {shift_q, data_in};
    assign w_byte_done = (state_q != IDLE) && bit_valid && (bit_cnt_q == 3'd7);

    // ------------------------------------------------------------------
    // FSM: next state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        len_cnt_d   = len_cnt_q;
        csum_d      = csum_q;
        done_d      = 1'b0;
        ok_d        = 1'b0;
        w_push_req  = 1'b0;
        w_push_last = 1'b0;

        // Bits are only consumed inside a frame; the sync cycle's bit is not.
        if (state_q != IDLE && bit_valid) begin
            shift_d   = w_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        case (state_q)
            IDLE: begin
                if (sync_found) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (w_byte_done) begin
                    len_cnt_d = w_byte;
                    csum_d    = w_byte;
                    state_d   = (w_byte != 8'h00) ? PAYLOAD : CHECK;
                end
            end
            PAYLOAD: begin
                if (w_byte_done) begin
                    csum_d      = csum_q ^ w_byte;
                    w_push_req  = 1'b1;
                    w_push_last = (len_cnt_q == 8'd1);
                    len_cnt_d   = len_cnt_q - 8'd1;
                    if (len_cnt_q == 8'd1) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (w_byte_done) begin
                    done_d  = 1'b1;
                    ok_d    = (w_byte == csum_q) && !ovf_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Overflow is sticky for the frame and re-armed when a new frame starts.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == IDLE && sync_found) begin
            ovf_d = 1'b0;
        end else if (w_push_drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 7'd0;
            len_cnt_q <= 8'd0;
            csum_q    <= 8'h00;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            len_cnt_q <= len_cnt_d;
            csum_q    <= csum_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            ok_q      <= ok_d;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    assign out_valid   = (count_q != '0);
    assign w_pop       = out_valid && out_ready;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign w_push_ok   = w_push_req && ((count_q != FULL_CNT) || w_pop);
    assign w_push_drop = w_push_req && !w_push_ok;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= {w_push_last, w_byte};
        end
    end

    // Pointers are ADDR_W bits wide, so increments wrap modulo FIFO_DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push_ok) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Head outputs read as zero when empty so reset and idle look clean.
    assign out_data   = out_valid ? mem_q[rd_ptr_q][7:0] : 8'h00;
    assign out_last   = out_valid ? mem_q[rd_ptr_q][8]   : 1'b0;
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;
    assign frame_ok   = ok_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_frame_receiver
//  Description : Self-checking bench for serial_frame_receiver. Directed
//                frames plus randomized frames are compared cycle by cycle
//                against a frame-level reference model built from bit counts,
//                byte indices and a queue standing in for the output buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_receiver;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_in;
    logic       bit_valid;
    logic       sync_found;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic       frame_done;
    logic       frame_ok;

    serial_frame_receiver #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .bit_valid  (bit_valid),
        .sync_found (sync_found),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_ok   (frame_ok)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: frame position is just "valid bits since sync".
    // ------------------------------------------------------------------
    logic [8:0] mq[$];          // expected buffer contents {last, data}
    logic [7:0] pay[$];         // payload bytes of the current frame
    bit         in_frame = 0;
    int         nbits    = 0;
    logic [7:0] cur      = 8'h00;
    int         flen     = 0;
    bit         ovf      = 0;
    bit         exp_done = 0;
    bit         exp_ok   = 0;

    logic [7:0] frame_q[$];     // stimulus frame: L, payload, checksum

    task automatic model_clear();
        mq.delete();
        pay.delete();
        in_frame = 0;
        nbits    = 0;
        ovf      = 0;
        exp_done = 0;
        exp_ok   = 0;
    endtask

    // Compare outputs, advance the model over the coming edge, clock once.
    task automatic cycle();
        bit         pop;
        bit         push;
        bit         plast;
        int         sz;
        int         idx;
        logic [7:0] x;
        bit         nd;
        bit         nok;
        #1;
        check_val("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) begin
            check_val("out_data", {24'd0, out_data}, {24'd0, mq[0][7:0]});
            check_val("out_last", {31'd0, out_last}, {31'd0, mq[0][8]});
        end
        check_val("busy", {31'd0, busy}, {31'd0, in_frame});
        check_val("frame_done", {31'd0, frame_done}, {31'd0, exp_done});
        if (exp_done) check_val("frame_ok", {31'd0, frame_ok}, {31'd0, exp_ok});

        pop   = (mq.size() != 0) && out_ready;
        sz    = mq.size();
        push  = 0;
        plast = 0;
        nd    = 0;
        nok   = 0;
        if (in_frame) begin
            if (bit_valid) begin
                cur = {cur[6:0], data_in};
                nbits++;
                if (nbits % 8 == 0) begin
                    idx = nbits / 8 - 1;
                    if (idx == 0) begin
                        flen = int'(cur);
                    end else if (idx <= flen) begin
                        pay.push_back(cur);
                        push  = 1;
                        plast = (idx == flen);
                    end else begin
                        x = flen[7:0];
                        foreach (pay[i]) x = x ^ pay[i];
                        nd       = 1;
                        nok      = (cur == x) && !ovf;
                        in_frame = 0;
                    end
                end
            end
        end else if (sync_found) begin
            in_frame = 1;
            nbits    = 0;
            ovf      = 0;
            pay.delete();
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (sz < DEPTH || pop) mq.push_back({plast, cur});
            else ovf = 1;
        end
        exp_done = nd;
        exp_ok   = nok;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic ready_of(input int mode);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            default: return logic'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_out_data", {24'd0, out_data}, 32'd0);
        check_val("rst_out_last", {31'd0, out_last}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check_val("rst_frame_ok", {31'd0, frame_ok}, 32'd0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle(input int n, input int rmode);
        for (int i = 0; i < n; i++) begin
            sync_found = 1'b0;
            bit_valid  = logic'($urandom_range(0, 1));
            data_in    = logic'($urandom_range(0, 1));
            out_ready  = ready_of(rmode);
            cycle();
        end
    endtask

    // gap_mode: 0 none, 1 gap after every bit, 2 random gaps.
    // abort_bits > 0 pulses reset after that many frame bits.
    task automatic send_frame(input int gap_mode, input int rmode, input bit noise, input int abort_bits);
        int   nb;
        logic [7:0] b;
        sync_found = 1'b1;
        bit_valid  = 1'b1;
        data_in    = logic'($urandom_range(0, 1));
        out_ready  = ready_of(rmode);
        cycle();
        nb = 0;
        foreach (frame_q[i]) begin
            b = frame_q[i];
            for (int k = 7; k >= 0; k--) begin
                if (gap_mode == 2) begin
                    while ($urandom_range(0, 2) == 0) begin
                        sync_found = noise && ($urandom_range(0, 3) == 0);
                        bit_valid  = 1'b0;
                        data_in    = logic'($urandom_range(0, 1));
                        out_ready  = ready_of(rmode);
                        cycle();
                    end
                end
                sync_found = noise && (nb % 5 == 2);
                bit_valid  = 1'b1;
                data_in    = b[k];
                out_ready  = ready_of(rmode);
                cycle();
                nb++;
                if (abort_bits > 0 && nb == abort_bits) begin
                    do_reset();
                    return;
                end
                if (gap_mode == 1) begin
                    sync_found = noise && (nb % 3 == 1);
                    bit_valid  = 1'b0;
                    data_in    = logic'($urandom_range(0, 1));
                    out_ready  = ready_of(rmode);
                    cycle();
                end
            end
        end
        sync_found = 1'b0;
    endtask

    task automatic build_frame(input int len, input bit bad);
        logic [7:0] x;
        logic [7:0] p;
        frame_q.delete();
        x = len[7:0];
        frame_q.push_back(len[7:0]);
        for (int i = 0; i < len; i++) begin
            p = 8'($urandom);
            frame_q.push_back(p);
            x = x ^ p;
        end
        frame_q.push_back(bad ? (x ^ 8'h01) : x);
    endtask

    task automatic nominal_frame(input logic [7:0] ck);
        frame_q.delete();
        frame_q.push_back(8'h02);
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'h3C);
        frame_q.push_back(ck);
    endtask

    initial begin
        rst        = 1'b1;
        data_in    = 1'b0;
        bit_valid  = 1'b0;
        sync_found = 1'b0;
        out_ready  = 1'b0;
        @(negedge clk);
        do_reset();

        // Nominal, bad checksum, zero length
        nominal_frame(8'h9B); send_frame(0, 1, 0, 0); idle(4, 1);
        nominal_frame(8'h9A); send_frame(0, 1, 0, 0); idle(4, 1);
        frame_q.delete(); frame_q.push_back(8'h00); frame_q.push_back(8'h00);
        send_frame(0, 1, 0, 0); idle(4, 1);

        // Backpressure: six bytes into a four-deep buffer, then drain
        build_frame(6, 0); send_frame(0, 0, 0, 0); idle(6, 0); idle(8, 1);

        // Gapped bits with sync pulses inside the frame
        nominal_frame(8'h9B); send_frame(1, 1, 1, 0); idle(4, 1);

        // Reset after the second payload bit, then a clean frame
        nominal_frame(8'h9B); send_frame(0, 1, 0, 10);
        nominal_frame(8'h9B); send_frame(0, 1, 0, 0); idle(4, 1);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            build_frame($urandom_range(0, 7), ($urandom_range(0, 3) == 0));
            send_frame(2, 2, 1, ($urandom_range(0, 7) == 0) ? $urandom_range(1, 20) : 0);
            idle($urandom_range(0, 6), 2);
        end
        idle(20, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_frame_receiver.md
SERIAL_FRAME_RECEIVER -- requirements
Module: serial_frame_receiver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output byte buffer depth (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port data_in  input  1  serial bit, MSB-first within each byte.
REQ-005 SHALL have port bit_valid  input  1  data_in is sampled only when high.
REQ-006 SHALL have port sync_found  input  1  one-cycle pulse from the upstream sync-pattern detector, coincident with the last sync bit.
REQ-007 SHALL have port out_data  output  8  payload byte at the FIFO head.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid byte.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the byte; transfer occurs when out_valid && out_ready.
REQ-010 SHALL have port out_last  output  1  head byte is the final payload byte of its frame.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at end of frame.
REQ-013 SHALL have port frame_ok  output  1  frame status, valid only while frame_done is high.

Function
REQ-014 SHALL implement the states IDLE, LEN, PAYLOAD and CHECK.
REQ-015 In IDLE with sync_found=1, SHALL move to LEN on the next edge.
  - The data_in bit of that cycle belongs to the sync pattern and SHALL NOT be consumed.
REQ-016 SHALL ignore sync_found in every state except IDLE (no resync mid-frame).
REQ-017 SHALL shift in one bit per cycle with bit_valid=1, using a 3-bit bit counter.
  - A byte completes on the 8th valid bit; cycles with bit_valid=0 hold all state.
REQ-018 In LEN, on byte completion, SHALL latch L into the byte counter and seed the running checksum with L.
  - Next state is PAYLOAD if L>0, else CHECK.
REQ-019 In PAYLOAD, on each byte completion, SHALL XOR the byte into the checksum, push it to the FIFO with out_last = (last payload byte), and decrement the counter.
  - Moves to CHECK after byte L.
REQ-020 In CHECK, on byte completion, SHALL pulse frame_done on the following cycle and return to IDLE on the same edge.
  - frame_ok = (received byte == running checksum) && !overflow.
REQ-021 A completed payload byte SHALL appear on out_valid in the cycle after its 8th bit is sampled if the FIFO was empty (latency 1).
REQ-022 A push SHALL be accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the byte is dropped and a sticky overflow flag is set for the current frame.
REQ-023 The overflow flag SHALL clear on entry to LEN.
REQ-024 Simultaneous push and pop with the FIFO non-empty SHALL leave the count unchanged and preserve order.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
  - The count register SHALL be wide enough to represent FIFO_DEPTH.
REQ-026 out_data and out_last SHALL remain stable while out_valid=1 && out_ready=0.
REQ-027 FIFO contents SHALL drain independently of the FSM, including after return to IDLE.

Reset
REQ-028 Asserting rst SHALL immediately force:
  - state=IDLE, all counters 0, checksum 0x00, FIFO empty, overflow 0;
  - out_valid=0, out_last=0, out_data=0x00, busy=0, frame_done=0, frame_ok=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame and all buffered bytes, with no frame_done pulse.
REQ-030 After rst deasserts, the block SHALL wait in IDLE for sync_found.

Verification
REQ-031 Nominal frame: sync_found, then L=0x02, payload 0xA5 0x3C, checksum 0x9B, bit_valid=1, out_ready=1.
  -> out_data 0xA5 then 0x3C (out_last=1 on 0x3C); frame_done=1 with frame_ok=1.
REQ-032 Bad checksum: same frame with checksum 0x9A.
  -> both bytes still delivered; frame_done=1 with frame_ok=0.
REQ-033 Zero length: L=0x00, checksum 0x00.
  -> no out_valid; frame_done=1 with frame_ok=1; busy drops the cycle after.
REQ-034 Backpressure: out_ready=0 throughout; L=0x06 with correct checksum; FIFO_DEPTH=4.
  -> 4 bytes held and stable; bytes 5-6 dropped; frame_done with frame_ok=0.
  -> out_ready=1 then drains exactly the first 4 bytes in order.
REQ-035 Gaps and ignored sync: bit_valid toggled 1/0 every cycle, with sync_found pulsed during PAYLOAD.
  -> identical bytes and status to REQ-031; no restart.
REQ-036 Reset mid-frame: rst pulsed after the 2nd payload bit.
  -> all outputs 0 immediately; a subsequent nominal frame is received correctly.
